// File: rtl/bit_stuff_pkg.sv
// Shared types and helpers for the bit_stuff_stream block.
package bit_stuff_pkg;

  typedef enum logic {
    PASS  = 1'b0,
    STUFF = 1'b1
  } stuff_state_t;

  localparam int DEFAULT_STUFF_LEN = 6;

  // Run counter must be able to hold the value STUFF_LEN itself.
  function automatic int run_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bit_stuff_stream.sv
// Streaming bit stuffer: inserts a 0 after every STUFF_LEN consecutive 1s per packet.
// Optional NRZI line coding of out_bit when BIT_STUFF_NRZI_EN is defined.
module bit_stuff_stream
  import bit_stuff_pkg::*;
#(
  parameter int STUFF_LEN = DEFAULT_STUFF_LEN,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic              out_stuffed,
  output logic [STAT_W-1:0] stuff_cnt,
  input  logic              stat_clr
);

  localparam int RUN_W = run_w(STUFF_LEN);

  stuff_state_t     state;
  logic [RUN_W-1:0] run_cnt;
  logic             data_bit;
  logic             stuff_last;
  logic             out_free;
  logic             accept;
  logic             hit;
  logic             stuff_load;

  assign out_free   = !out_valid || out_ready;
  assign in_ready   = (state == PASS) && out_free;
  assign accept     = in_valid && in_ready;
  assign hit        = in_bit && ((run_cnt + RUN_W'(1)) == RUN_W'(STUFF_LEN));
  assign stuff_load = (state == STUFF) && out_free;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state       <= PASS;
      run_cnt     <= '0;
      out_valid   <= 1'b0;
      data_bit    <= 1'b0;
      out_last    <= 1'b0;
      out_stuffed <= 1'b0;
      stuff_last  <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      data_bit    <= in_bit;
      out_stuffed <= 1'b0;
      if (hit) begin
        // The packet end migrates onto the stuff bit that follows.
        state      <= STUFF;
        out_last   <= 1'b0;
        stuff_last <= in_last;
        run_cnt    <= in_last ? '0 : RUN_W'(STUFF_LEN);
      end else begin
        out_last <= in_last;
        run_cnt  <= (in_last || !in_bit) ? '0 : run_cnt + RUN_W'(1);
      end
    end else if (stuff_load) begin
      state       <= PASS;
      run_cnt     <= '0;
      out_valid   <= 1'b1;
      data_bit    <= 1'b0;
      out_stuffed <= 1'b1;
      out_last    <= stuff_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BIT_STUFF_NRZI_EN
  // line_lvl is the level left on the wire by the last transferred bit.
  logic line_lvl;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      line_lvl <= 1'b1;
    end else if (out_valid && out_ready && !data_bit) begin
      line_lvl <= ~line_lvl;
    end
  end

  assign out_bit = data_bit ? line_lvl : ~line_lvl;
`else
  assign out_bit = data_bit;
`endif

  sat_counter #(
    .W(STAT_W)
  ) u_stat (
    .clk  (clk),
    .rst_n(rst_L),
    .clr  (stat_clr),
    .inc  (stuff_load),
    .cnt  (stuff_cnt)
  );

endmodule
